// File: rtl/mips64_pkg.sv
// Shared constants and types for the register scoreboard and its helpers.
package mips64_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned ZERO_REG   = 0;
  localparam int unsigned CNT_OUT_W  = 6;

  // Decode-side hazard tracking: RUN while issuing freely, HOLD while stalled.
  typedef enum logic {
    SB_RUN  = 1'b0,
    SB_HOLD = 1'b1
  } sb_state_e;

endpackage

// File: rtl/sb_decode5to32.sv
// Register index to one-hot decoder; the zero register never decodes.
module sb_decode5to32
  import mips64_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] idx_i,
  input  logic                  en_i,
  output logic [NUM_REGS-1:0]   oh_o
);

  // One-hot of idx_i when enabled, bit 0 always cleared.
  always_comb begin
    oh_o = '0;
    if (en_i) begin
      oh_o[idx_i] = 1'b1;
    end
    oh_o[ZERO_REG] = 1'b0;
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding writes and raises RAW/WAW stalls.
module reg_scoreboard
  import mips64_pkg::REG_ADDR_W;
  import mips64_pkg::ZERO_REG;
  import mips64_pkg::CNT_OUT_W;
  import mips64_pkg::sb_state_e;
  import mips64_pkg::SB_RUN;
  import mips64_pkg::SB_HOLD;
#(
  parameter int unsigned NUM_REGS = mips64_pkg::NUM_REGS,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic                  issue_wen,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic [REG_ADDR_W-1:0] src_rs,
  input  logic [REG_ADDR_W-1:0] src_rt,
  input  logic                  rs_used,
  input  logic                  rt_used,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issue_ack,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [CNT_OUT_W-1:0]  pending_count,
  output logic                  wb_err,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int unsigned DEC_W = mips64_pkg::NUM_REGS;

  logic [NUM_REGS-1:0]  pending_q, pending_d;
  logic [CNT_OUT_W-1:0] count_q, count_d;
  logic                 wb_err_q, wb_err_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  sb_state_e            state_q, state_d;

  logic [DEC_W-1:0]     set_dec, wb_dec;
  logic [NUM_REGS-1:0]  set_vec, clr_vec, eff_pend;
  logic                 set_en_c;
  logic                 rs_hz, rt_hz, waw_hz;

  // Accepted writing instructions mark their destination.
  assign set_en_c = issue_ack & issue_wen;

  sb_decode5to32 u_dec_issue (
    .idx_i (issue_dest),
    .en_i  (set_en_c),
    .oh_o  (set_dec)
  );

  sb_decode5to32 u_dec_wb (
    .idx_i (wb_dest),
    .en_i  (wb_valid),
    .oh_o  (wb_dec)
  );

  assign set_vec = NUM_REGS'(set_dec);
  assign clr_vec = NUM_REGS'(wb_dec);

  // Same-cycle write-back bypasses the hazard on its register.
  assign eff_pend = pending_q & ~clr_vec;

  assign rs_hz  = rs_used   & eff_pend[src_rs];
  assign rt_hz  = rt_used   & eff_pend[src_rt];
  assign waw_hz = issue_wen & eff_pend[issue_dest];

  assign stall     = issue_valid & ~flush & (rs_hz | rt_hz | waw_hz);
  assign issue_ack = issue_valid & ~stall;

  // Next pending set: flush empties it, otherwise clear then set so set wins.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      pending_d = (pending_q & ~clr_vec) | set_vec;
    end
  end

  // Population count of the next mask so the count tracks the mask edge-for-edge.
  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      count_d = count_d + CNT_OUT_W'(pending_d[i]);
    end
  end

  // Write-back to a non-pending, non-zero register is an error unless flushing.
  always_comb begin
    wb_err_d = 1'b0;
    if (wb_valid && !flush && (wb_dest != REG_ADDR_W'(ZERO_REG)) && !pending_q[wb_dest]) begin
      wb_err_d = 1'b1;
    end
  end

  // Saturating count of stalled issue cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // RUN/HOLD next-state logic tracking the stall condition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_RUN: begin
        if (stall) begin
          state_d = SB_HOLD;
        end
      end
      SB_HOLD: begin
        if (!stall || flush) begin
          state_d = SB_RUN;
        end
      end
      default: begin
        state_d = SB_RUN;
      end
    endcase
  end

  // State register for the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SB_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Scoreboard, status and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      count_q     <= '0;
      wb_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      count_q     <= count_d;
      wb_err_q    <= wb_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pending_mask  = pending_q;
  assign pending_count = count_q;
  assign wb_err        = wb_err_q;
  assign stall_cycles  = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed hazard scenarios plus random traffic.
module tb_reg_scoreboard;

  typedef struct {
    logic [31:0] mask;
    logic [5:0]  cnt;
    logic        err;
    logic [15:0] sc;
    logic [3:0]  sc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_wen, rs_used, rt_used, wb_valid, flush;
  logic [4:0]  issue_dest, src_rs, src_rt, wb_dest;

  logic        stall, issue_ack, wb_err;
  logic [31:0] pending_mask;
  logic [5:0]  pending_count;
  logic [15:0] stall_cycles;

  logic        stall4, ack4, err4;
  logic [31:0] mask4;
  logic [5:0]  cnt4;
  logic [3:0]  sc4_out;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  bit          pend [32];
  int unsigned sc_m  = 0;
  int unsigned sc4_m = 0;
  exp_t        exp_q [$];

  always #5 clk = ~clk;

  reg_scoreboard #(.NUM_REGS(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_dest(issue_dest), .src_rs(src_rs), .src_rt(src_rt), .rs_used(rs_used),
    .rt_used(rt_used), .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
    .stall(stall), .issue_ack(issue_ack), .pending_mask(pending_mask),
    .pending_count(pending_count), .wb_err(wb_err), .stall_cycles(stall_cycles)
  );

  reg_scoreboard #(.NUM_REGS(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_dest(issue_dest), .src_rs(src_rs), .src_rt(src_rt), .rs_used(rs_used),
    .rt_used(rt_used), .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
    .stall(stall4), .issue_ack(ack4), .pending_mask(mask4),
    .pending_count(cnt4), .wb_err(err4), .stall_cycles(sc4_out)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t snap(input bit err);
    exp_t e;
    e.mask = '0;
    e.cnt  = '0;
    for (int n = 0; n < 32; n++) begin
      e.mask[n] = pend[n];
      e.cnt     = e.cnt + 6'(pend[n]);
    end
    e.err = err;
    e.sc  = 16'(sc_m);
    e.sc4 = 4'(sc4_m);
    return e;
  endfunction

  task automatic idle();
    issue_valid = 1'b0; issue_wen = 1'b0; issue_dest = '0;
    src_rs = '0; src_rt = '0; rs_used = 1'b0; rt_used = 1'b0;
    wb_valid = 1'b0; wb_dest = '0; flush = 1'b0;
  endtask

  // Drive one cycle of inputs, check the combinational response, queue the registered one.
  task automatic step(input bit v, input bit w, input int d, input int rs, input int rt,
                      input bit ru, input bit tu, input bit wv, input int wd, input bit fl);
    bit eff [32];
    bit hz, es, ea, er;
    @(posedge clk);
    #2;
    issue_valid = v; issue_wen = w; issue_dest = 5'(d);
    src_rs = 5'(rs); src_rt = 5'(rt); rs_used = ru; rt_used = tu;
    wb_valid = wv; wb_dest = 5'(wd); flush = fl;
    #2;
    for (int n = 0; n < 32; n++) eff[n] = pend[n] && !(wv && wd == n);
    hz = (ru && eff[rs]) || (tu && eff[rt]) || (w && eff[d]);
    es = v && !fl && hz;
    ea = v && !es;
    chk("stall", 32'(stall), 32'(es));
    chk("issue_ack", 32'(issue_ack), 32'(ea));
    chk("stall_w4", 32'(stall4), 32'(es));
    chk("issue_ack_w4", 32'(ack4), 32'(ea));
    er = 1'b0;
    if (fl) begin
      for (int n = 0; n < 32; n++) pend[n] = 1'b0;
    end else begin
      er = wv && (wd != 0) && !pend[wd];
      if (wv) pend[wd] = 1'b0;
      if (ea && w && d != 0) pend[d] = 1'b1;
    end
    if (es) begin
      if (sc_m < 65535) sc_m++;
      if (sc4_m < 15) sc4_m++;
    end
    exp_q.push_back(snap(er));
  endtask

  // Reset asserted between edges in the middle of traffic.
  task automatic reset_mid();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_mask", pending_mask, 32'h0);
    chk("rst_count", 32'(pending_count), 32'h0);
    chk("rst_wb_err", 32'(wb_err), 32'h0);
    chk("rst_stall_cycles", 32'(stall_cycles), 32'h0);
    chk("rst_stall_cycles_w4", 32'(sc4_out), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    for (int n = 0; n < 32; n++) pend[n] = 1'b0;
    sc_m  = 0;
    sc4_m = 0;
    exp_q.push_back(snap(1'b0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.push_back(snap(1'b0));
  endtask

  function automatic int pick_wb();
    int r;
    r = int'($urandom_range(0, 31));
    if ($urandom_range(0, 3) != 0) begin
      for (int k = 0; k < 32; k++) begin
        if (pend[(r + k) % 32]) return (r + k) % 32;
      end
    end
    return r;
  endfunction

  // Monitor: after every edge, compare registered outputs with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pending_mask", pending_mask, e.mask);
        chk("pending_count", 32'(pending_count), 32'(e.cnt));
        chk("wb_err", 32'(wb_err), 32'(e.err));
        chk("stall_cycles", 32'(stall_cycles), 32'(e.sc));
        chk("pending_mask_w4", mask4, e.mask);
        chk("pending_count_w4", 32'(cnt4), 32'(e.cnt));
        chk("wb_err_w4", 32'(err4), 32'(e.err));
        chk("stall_cycles_w4", 32'(sc4_out), 32'(e.sc4));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d, rs, rt;
    bit v, w, ru, tu, wv, fl;
    rst_n = 1'b0;
    idle();
    #12;
    chk("init_mask", pending_mask, 32'h0);
    chk("init_count", 32'(pending_count), 32'h0);
    chk("init_wb_err", 32'(wb_err), 32'h0);
    chk("init_stall_cycles", 32'(stall_cycles), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // RAW on r5, then same-cycle write-back releases it
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 5, 0, 1, 0, 0, 0, 0);
    chk("raw_stall", 32'(stall), 32'h1);
    step(1, 0, 0, 5, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 5, 0, 1, 0, 1, 5, 0);
    chk("raw_bypass_stall", 32'(stall), 32'h0);
    chk("raw_bypass_ack", 32'(issue_ack), 32'h1);

    // Zero register never pending
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("zero_stall", 32'(stall), 32'h0);

    // Simultaneous set and clear on r7
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
    chk("setclr_ack", 32'(issue_ack), 32'h1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("setclr_bit7", 32'(pending_mask[7]), 32'h1);

    // Illegal write-back on an empty board
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Flush with a concurrent issue
    step(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 31, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 6, 3, 4, 1, 1, 0, 0, 1);
    chk("flush_stall", 32'(stall), 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a stall, then saturate the narrow counter
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 5, 0, 1, 0, 0, 0, 0);
    reset_mid();
    step(1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 10, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_w4", 32'(sc4_out), 32'd15);
    chk("count_20", 32'(stall_cycles), 32'd20);
    step(0, 0, 0, 0, 0, 0, 0, 1, 10, 0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      rs = $urandom_range(0, 7);
      rt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      v  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 1) != 0);
      ru = ($urandom_range(0, 1) != 0);
      tu = ($urandom_range(0, 1) != 0);
      wv = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 39) == 0);
      step(v, w, int'(d), int'(rs), int'(rt), ru, tu, wv, pick_wb(), fl);
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
